prime_stream_gen: RTL and testbench

- Companion to the registered prime checker: it produces primes instead of testing them.
- On a start pulse, enumerates every prime p with 2 <= p <= limit in ascending order.
- Each prime is emitted on a valid/ready stream, then a one-cycle done pulse is raised.
- Primality is decided by a sequential trial-division engine using repeated subtraction; no combinational divider.

---
 rtl/prime_pkg.sv | 17 +
 rtl/prime_trial_div.sv | 67 ++++++
 rtl/prime_stream_gen.sv | 146 ++++++++++++++
 tb/tb_prime_stream_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_pkg.sv
// Shared definitions for the prime stream generator.
//   state_t          : top-level run states
//   DEFAULT_WIDTH    : default width of limit / candidate / count datapath
//   PRIME_COUNT_255  : number of primes in [2, 255], used by benches
package prime_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int PRIME_COUNT_255 = 54;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/prime_trial_div.sv
// Sequential trial-division primality engine using repeated subtraction.
// A go pulse loads a candidate; the engine then performs one action per
// cycle until it can decide, at which point result_valid is raised
// combinationally for that cycle and busy falls on the next edge.
//   clk, rst      : clock, asynchronous active-high reset
//   go            : load cand and start testing (wins over a finishing test)
//   cand          : candidate to test, sampled on go
//   busy          : a test is in progress
//   result_valid  : decision available this cycle
//   is_prime      : decision, meaningful only with result_valid
module prime_trial_div
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] cand,
  output logic             busy,
  output logic             result_valid,
  output logic             is_prime
);

  logic [WIDTH-1:0]   cand_r;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   r;
  logic [2*WIDTH-1:0] d_sq;
  logic               sq_exceeds;
  logic               composite;

  // Once d*d passes the candidate no divisor remains, so it is prime. The
  // square is taken at double width so it cannot wrap.
  assign d_sq       = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
  assign sq_exceeds = d_sq > {{WIDTH{1'b0}}, cand_r};
  // r has been reduced below d; a zero remainder means d divides cand.
  assign composite  = !sq_exceeds && (r < d) && (r == '0);

  assign result_valid = busy && (sq_exceeds || composite);
  assign is_prime     = sq_exceeds;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cand_r <= '0;
      d      <= '0;
      r      <= '0;
    end else if (go) begin
      busy   <= 1'b1;
      cand_r <= cand;
      d      <= WIDTH'(2);
      r      <= cand;
    end else if (busy) begin
      if (sq_exceeds || composite) begin
        busy <= 1'b0;
      end else if (r >= d) begin
        r <= r - d;
      end else begin
        d <= d + WIDTH'(1);
        r <= cand_r;
      end
    end
  end

endmodule

// File: rtl/prime_stream_gen.sv
// Prime stream generator: on an accepted start, enumerates every prime p with
// 2 <= p <= limit in ascending order over a valid/ready stream, then pulses
// done for one cycle. Primality comes from the prime_trial_div engine.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : run request, accepted only in IDLE
//   limit        : inclusive upper bound, sampled on an accepted start
//   busy         : high in every state except IDLE
//   prime_out    : prime being offered (registered)
//   prime_valid  : prime_out holds a prime (registered)
//   prime_ready  : downstream accepts prime_out
//   done         : one-cycle pulse at the end of a run
//   count        : primes handed off in the current or last run
module prime_stream_gen
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic [WIDTH-1:0] prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] lim_r, lim_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             valid_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             adv;

  logic             div_go;
  logic [WIDTH-1:0] div_cand;
  logic             div_busy;
  logic             div_result_valid;
  logic             div_is_prime;

  prime_trial_div #(.WIDTH(WIDTH)) u_div (
    .clk          (clk),
    .rst          (rst),
    .go           (div_go),
    .cand         (div_cand),
    .busy         (div_busy),
    .result_valid (div_result_valid),
    .is_prime     (div_is_prime)
  );

  assign busy = (state != IDLE);

  // NOTE: every signal written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    lim_nxt   = lim_r;
    cand_nxt  = cand;
    out_nxt   = prime_out;
    valid_nxt = prime_valid;
    done_nxt  = 1'b0;
    count_nxt = count;
    div_go    = 1'b0;
    div_cand  = cand + WIDTH'(1);
    adv       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          lim_nxt   = limit;
          count_nxt = '0;
          if (limit < WIDTH'(2)) begin
            state_nxt = FIN;
          end else begin
            cand_nxt  = WIDTH'(2);
            div_cand  = WIDTH'(2);
            div_go    = 1'b1;
            state_nxt = TEST;
          end
        end
      end
      TEST: begin
        if (div_busy && div_result_valid) begin
          if (div_is_prime) begin
            state_nxt = EMIT;
            valid_nxt = 1'b1;
            out_nxt   = cand;
          end else begin
            adv = 1'b1;
          end
        end
      end
      EMIT: begin
        if (prime_valid && prime_ready) begin
          count_nxt = count + WIDTH'(1);
          valid_nxt = 1'b0;
          adv       = 1'b1;
        end
      end
      FIN: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Advance to the next candidate. The limit compare happens before the
    // increment, so a limit of all-ones finishes without wrapping.
    if (adv) begin
      if (cand == lim_r) begin
        state_nxt = FIN;
      end else begin
        cand_nxt  = cand + WIDTH'(1);
        div_go    = 1'b1;
        state_nxt = TEST;
      end
    end
  end

  // NOTE: all registers here are control/datapath flops (no memories), so
  // each one is cleared by reset; an abandoned run leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lim_r       <= '0;
      cand        <= '0;
      prime_out   <= '0;
      prime_valid <= 1'b0;
      done        <= 1'b0;
      count       <= '0;
    end else begin
      state       <= state_nxt;
      lim_r       <= lim_nxt;
      cand        <= cand_nxt;
      prime_out   <= out_nxt;
      prime_valid <= valid_nxt;
      done        <= done_nxt;
      count       <= count_nxt;
    end
  end

endmodule

// File: tb/tb_prime_stream_gen.sv
// Self-checking bench for prime_stream_gen. A reference list of primes is
// built by plain modulo trial division; every cycle the stream, the count
// and the handshake stability are compared against it.
module tb_prime_stream_gen;
  import prime_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] limit = '0;
  logic         busy;
  logic [W-1:0] prime_out;
  logic         prime_valid;
  logic         prime_ready = 1'b1;
  logic         done;
  logic [W-1:0] count;

  prime_stream_gen #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .limit       (limit),
    .busy        (busy),
    .prime_out   (prime_out),
    .prime_valid (prime_valid),
    .prime_ready (prime_ready),
    .done        (done),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int exp_q[$];
  int exp_count = 0;
  int exp_total = 0;
  int last_rx   = -1;
  bit mdl_on    = 1'b0;
  int ready_mode = 0;   // 0: tied high, 1: random ~30%, 2: held low

  bit last_valid = 1'b0;
  bit last_ready = 1'b0;
  int last_out   = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_prime_ref(input int n);
    if (n < 2) return 1'b0;
    for (int k = 2; k * k <= n; k++)
      if (n % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: inputs change 1 time unit after the rising edge, outputs are
  // compared on the falling edge against the reference list.
  task automatic cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    case (ready_mode)
      0:       prime_ready = 1'b1;
      1:       prime_ready = ($urandom_range(0, 99) < 30);
      default: prime_ready = 1'b0;
    endcase
    @(negedge clk);
    if (!rst && mdl_on) begin
      check("count", count, exp_count);
      if (last_valid && !last_ready) begin
        check("stall_valid", prime_valid, 1);
        check("stall_data", prime_out, last_out);
      end
      if (prime_valid) begin
        check("prime_out", prime_out, (exp_q.size() != 0) ? exp_q[0] : 256);
        if (prime_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          exp_count++;
          last_rx = prime_out;
        end
      end
      if (done) check("done_with_pending", exp_q.size(), 0);
    end
    last_valid = prime_valid;
    last_ready = prime_ready;
    last_out   = prime_out;
  endtask

  // Called on a falling edge: pulse start and set up the expected stream.
  task automatic start_run(input int lim);
    start = 1'b1;
    limit = W'(lim);
    exp_q.delete();
    for (int n = 2; n <= lim; n++)
      if (is_prime_ref(n)) exp_q.push_back(n);
    exp_total = exp_q.size();
    exp_count = 0;
    last_rx   = -1;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    check("busy_after_done", busy, 0);
    check("count_final", count, exp_total);
    check("pending_primes", exp_q.size(), 0);
    cycle();
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", prime_valid, 0);
    check("rst_done", done, 0);
    check("rst_prime_out", prime_out, 0);
    check("rst_count", count, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    mdl_on = 1'b1;
    cycle();

    // limit=10 with ready tied high; first valid two cycles after start.
    ready_mode = 0;
    start_run(10);
    cycle();
    check("l10_busy_test", busy, 1);
    check("l10_valid_early", prime_valid, 0);
    cycle();
    check("l10_valid_latency", prime_valid, 1);
    wait_done(4000);
    check("l10_count", count, 4);
    check("l10_last", last_rx, 7);

    // limit=0 and limit=1: no primes, done two cycles after start.
    for (int l = 0; l < 2; l++) begin
      start_run(l);
      cycle();
      check("small_busy", busy, 1);
      check("small_done_early", done, 0);
      cycle();
      check("small_done", done, 1);
      check("small_busy_drop", busy, 0);
      check("small_count", count, 0);
      cycle();
      check("small_done_width", done, 0);
    end

    // limit=2: a single prime.
    start_run(2);
    wait_done(4000);
    check("l2_count", count, 1);
    check("l2_last", last_rx, 2);

    // limit=255: all 54 primes, must end without wrapping the candidate.
    start_run(255);
    wait_done(60000);
    check("l255_count", count, PRIME_COUNT_255);
    check("l255_last", last_rx, 251);
    for (int i = 0; i < 3; i++) cycle();
    check("l255_stays_idle", busy, 0);

    // limit=50 with random backpressure.
    ready_mode = 1;
    start_run(50);
    wait_done(4000);
    check("l50_count", count, 15);
    check("l50_last", last_rx, 47);

    // start pulsed in TEST and in EMIT with another limit is ignored.
    ready_mode = 2;
    start_run(20);
    cycle();
    start = 1'b1;
    limit = W'(3);
    cycle();
    check("ign_valid", prime_valid, 1);
    start = 1'b1;
    limit = W'(100);
    for (int i = 0; i < 4; i++) cycle();
    ready_mode = 0;
    wait_done(4000);
    check("ign_count", count, 8);
    check("ign_last", last_rx, 19);

    // Reset while prime 5 is being offered.
    ready_mode = 0;
    start_run(20);
    for (int i = 0; i < 500 && !(prime_valid && prime_out == W'(5)); i++) cycle();
    check("rst_mid_at5", prime_out, 5);
    #2;
    mdl_on = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", prime_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", count, 0);
    exp_q.delete();
    exp_count = 0;
    cycle();
    cycle();
    #2 rst = 1'b0;
    last_valid = 1'b0;
    mdl_on = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    check("rst_no_resume", busy, 0);

    start_run(7);
    wait_done(4000);
    check("l7_count", count, 4);
    check("l7_last", last_rx, 7);

    // A few random limits under random backpressure.
    ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      start_run($urandom_range(0, 60));
      wait_done(4000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
